// File: rtl/layer_render_pipeline.sv
// Composites background tile, animated sprite and score glyphs into one colour index per pixel.
// Latency 3 cycles (address, ROM read, composite); oValid = iValid delayed 3; no back-pressure.
module layer_render_pipeline #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int BG_WIDTH      = 260,
  parameter int BIRD_X        = 303,
  parameter int BIRD_WIDTH    = 34,
  parameter int BIRD_HEIGHT   = 24,
  parameter int BIRD_FRAMES   = 3,
  parameter int FLAP_DIV      = 6,
  parameter int SCROLL_DIV    = 1,
  parameter int NUM_DIGITS    = 3,
  parameter int DIGIT_WIDTH   = 24,
  parameter int DIGIT_HEIGHT  = 44,
  parameter int SCORE_X       = 10,
  parameter int SCORE_Y       = 10,
  parameter int SCORE_MARGIN  = 5,
  parameter int LEADING_ZEROS = 0
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iValid,
  input  logic [18:0] iAddress,
  input  logic [9:0]  iBirdY,
  input  logic [15:0] iScore,
  output logic [16:0] oBgAddr,
  input  logic [15:0] iBgIdx,
  output logic [11:0] oBirdAddr,
  input  logic [15:0] iBirdIdx,
  output logic [13:0] oDigitAddr,
  input  logic [15:0] iDigitIdx,
  output logic [15:0] oColorIndex,
  output logic        oValid
);

  localparam int MAX_SCORE = (10 ** NUM_DIGITS) - 1;
  localparam int PITCH     = DIGIT_WIDTH + SCORE_MARGIN;

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} conv_state_t;

  // Position counters hold the coordinates of the next pixel to arrive.
  logic [10:0] x_q, y_q;
  logic [15:0] bgx_q;
  logic [16:0] row_q;
  logic [15:0] scroll_q, scroll_nxt_q, scroll_div_q;
  logic [7:0]  anim_q, anim_nxt_q;
  logic [15:0] anim_div_q;
  logic [9:0]  bird_y_q;

  logic        frame_start;
  logic [10:0] cur_x, cur_y;
  logic [15:0] cur_bgx, cur_scroll;
  logic [16:0] cur_row;
  logic [7:0]  cur_anim;
  logic [9:0]  cur_bird_y;

  // The frame-start pixel itself already sees the new frame's state.
  assign frame_start = iValid && (iAddress == 19'd0);
  assign cur_x       = frame_start ? 11'd0 : x_q;
  assign cur_y       = frame_start ? 11'd0 : y_q;
  assign cur_bgx     = frame_start ? scroll_nxt_q : bgx_q;
  assign cur_scroll  = frame_start ? scroll_nxt_q : scroll_q;
  assign cur_row     = frame_start ? 17'd0 : row_q;
  assign cur_anim    = frame_start ? anim_nxt_q : anim_q;
  assign cur_bird_y  = frame_start ? iBirdY : bird_y_q;

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      x_q          <= '0;
      y_q          <= '0;
      bgx_q        <= '0;
      row_q        <= '0;
      scroll_q     <= '0;
      scroll_nxt_q <= '0;
      scroll_div_q <= '0;
      anim_q       <= '0;
      anim_nxt_q   <= '0;
      anim_div_q   <= '0;
      bird_y_q     <= '0;
    end else begin
      if (frame_start) begin
        bird_y_q <= iBirdY;
        scroll_q <= scroll_nxt_q;
        anim_q   <= anim_nxt_q;
        if (scroll_div_q == 16'(SCROLL_DIV - 1)) begin
          scroll_div_q <= '0;
          scroll_nxt_q <= (scroll_nxt_q == 16'(BG_WIDTH - 1)) ? 16'd0 : scroll_nxt_q + 16'd1;
        end else begin
          scroll_div_q <= scroll_div_q + 16'd1;
        end
        if (anim_div_q == 16'(FLAP_DIV - 1)) begin
          anim_div_q <= '0;
          anim_nxt_q <= (anim_nxt_q == 8'(BIRD_FRAMES - 1)) ? 8'd0 : anim_nxt_q + 8'd1;
        end else begin
          anim_div_q <= anim_div_q + 16'd1;
        end
      end
      if (iValid) begin
        if (cur_x == 11'(SCREEN_WIDTH - 1)) begin
          x_q   <= '0;
          y_q   <= cur_y + 11'd1;
          bgx_q <= cur_scroll;
          row_q <= cur_row + 17'(BG_WIDTH);
        end else begin
          x_q   <= cur_x + 11'd1;
          y_q   <= cur_y;
          bgx_q <= (cur_bgx == 16'(BG_WIDTH - 1)) ? 16'd0 : cur_bgx + 16'd1;
          row_q <= cur_row;
        end
      end
    end
  end

  // Sprite region, compared at 11 bits so a low sprite clips instead of wrapping.
  logic [10:0] bird_top, bird_bot;
  logic        in_bird;
  logic [11:0] bird_addr;

  assign bird_top  = {1'b0, cur_bird_y};
  assign bird_bot  = bird_top + 11'(BIRD_HEIGHT);
  assign in_bird   = (cur_x >= 11'(BIRD_X)) && (cur_x < 11'(BIRD_X + BIRD_WIDTH)) &&
                     (cur_y >= bird_top) && (cur_y < bird_bot);
  assign bird_addr = in_bird ? (12'(cur_anim) * 12'(BIRD_WIDTH * BIRD_HEIGHT) +
                                12'(cur_y - bird_top) * 12'(BIRD_WIDTH) +
                                12'(cur_x - 11'(BIRD_X))) : 12'd0;

  logic [3:0]  disp_dig [NUM_DIGITS];
  logic [3:0]  work_dig [NUM_DIGITS];
  logic        glyph_hit, glyph_vis, glyph_seen, in_glyph_rows;
  logic [3:0]  glyph_digit;
  logic [10:0] glyph_col;
  logic [13:0] digit_addr;

  assign in_glyph_rows = (cur_y >= 11'(SCORE_Y)) && (cur_y < 11'(SCORE_Y + DIGIT_HEIGHT));

  // glyph_seen turns on at the first non-zero digit; the rightmost glyph always shows.
  always_comb begin
    glyph_hit   = 1'b0;
    glyph_vis   = 1'b0;
    glyph_digit = '0;
    glyph_col   = '0;
    glyph_seen  = (LEADING_ZEROS != 0);
    for (int g = 0; g < NUM_DIGITS; g++) begin
      glyph_seen = glyph_seen || (disp_dig[g] != 4'd0) || (g == NUM_DIGITS - 1);
      if ((cur_x >= 11'(SCORE_X + g * PITCH)) && (cur_x < 11'(SCORE_X + g * PITCH + DIGIT_WIDTH))) begin
        glyph_hit   = 1'b1;
        glyph_vis   = glyph_seen;
        glyph_digit = disp_dig[g];
        glyph_col   = cur_x - 11'(SCORE_X + g * PITCH);
      end
    end
    glyph_hit = glyph_hit && in_glyph_rows;
  end

  assign digit_addr = glyph_hit ? (14'(glyph_digit) * 14'(DIGIT_WIDTH * DIGIT_HEIGHT) +
                                   14'(cur_y - 11'(SCORE_Y)) * 14'(DIGIT_WIDTH) +
                                   14'(glyph_col)) : 14'd0;

  logic v1_q, v2_q;
  logic bird_f1_q, bird_f2_q, glyph_f1_q, glyph_f2_q;

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      oValid      <= 1'b0;
      oBgAddr     <= '0;
      oBirdAddr   <= '0;
      oDigitAddr  <= '0;
      bird_f1_q   <= 1'b0;
      bird_f2_q   <= 1'b0;
      glyph_f1_q  <= 1'b0;
      glyph_f2_q  <= 1'b0;
      oColorIndex <= '0;
    end else begin
      v1_q   <= iValid;
      v2_q   <= v1_q;
      oValid <= v2_q;
      if (iValid) begin
        oBgAddr    <= 17'(cur_bgx) + cur_row;
        oBirdAddr  <= bird_addr;
        oDigitAddr <= digit_addr;
        bird_f1_q  <= in_bird;
        glyph_f1_q <= glyph_hit && glyph_vis;
      end
      bird_f2_q  <= bird_f1_q;
      glyph_f2_q <= glyph_f1_q;
      if (v2_q) begin
        if (bird_f2_q && (iBirdIdx != 16'd0))
          oColorIndex <= iBirdIdx;
        else if (glyph_f2_q && (iDigitIdx != 16'd0))
          oColorIndex <= iDigitIdx;
        else
          oColorIndex <= iBgIdx;
      end
    end
  end

  // Score conversion: repeated subtraction, one power of ten per cycle, leftmost glyph first.
  conv_state_t conv_state;
  logic [15:0] conv_val, cur_pow, conv_rem, score_clamped;
  logic [3:0]  conv_g, conv_acc, digit_now;
  logic        digit_resolved;

  always_comb begin
    cur_pow = 16'd1;
    for (int g = 0; g < NUM_DIGITS; g++)
      if (conv_g == 4'(g)) cur_pow = 16'(10 ** (NUM_DIGITS - 1 - g));
  end

  assign conv_rem       = conv_val - cur_pow;
  assign digit_resolved = (conv_val < cur_pow) || (conv_rem < cur_pow);
  assign digit_now      = (conv_val < cur_pow) ? conv_acc : conv_acc + 4'd1;
  assign score_clamped  = ({16'd0, iScore} > 32'(MAX_SCORE)) ? 16'(MAX_SCORE) : iScore;

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      conv_state <= IDLE;
      conv_val   <= '0;
      conv_g     <= '0;
      conv_acc   <= '0;
      for (int g = 0; g < NUM_DIGITS; g++) begin
        work_dig[g] <= '0;
        disp_dig[g] <= '0;
      end
    end else begin
      if (conv_state == DONE)
        for (int g = 0; g < NUM_DIGITS; g++) disp_dig[g] <= work_dig[g];
      if (frame_start) begin
        conv_state <= CONVERT;
        conv_val   <= score_clamped;
        conv_g     <= '0;
        conv_acc   <= '0;
      end else begin
        case (conv_state)
          CONVERT: begin
            if (conv_val >= cur_pow) begin
              conv_val <= conv_rem;
              conv_acc <= conv_acc + 4'd1;
            end
            if (digit_resolved) begin
              for (int g = 0; g < NUM_DIGITS; g++)
                if (conv_g == 4'(g)) work_dig[g] <= digit_now;
              conv_acc <= '0;
              if (conv_g == 4'(NUM_DIGITS - 1))
                conv_state <= DONE;
              else
                conv_g <= conv_g + 4'd1;
            end
          end
          DONE:    conv_state <= IDLE;
          default: conv_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_layer_render_pipeline.sv
// Randomized scoreboard bench for layer_render_pipeline with a per-pixel reference model.
module tb_layer_render_pipeline;

  localparam int SW = 48, SH = 32, BGW = 20;
  localparam int BX = 12, BW = 6, BH = 5, BF = 3, FD = 2, SD = 1;
  localparam int ND = 3, DW = 4, DH = 5, SX = 2, SY = 2, SM = 1, LZ = 0;
  localparam int FULL = SW * SH;
  localparam int MAXS = 10 ** ND - 1;

  logic        iClock = 1'b0;
  logic        iReset = 1'b1;
  logic        iValid = 1'b0;
  logic [18:0] iAddress = '0;
  logic [9:0]  iBirdY = '0;
  logic [15:0] iScore = '0;
  logic [15:0] iBgIdx = '0, iBirdIdx = '0, iDigitIdx = '0;
  logic [16:0] oBgAddr;
  logic [11:0] oBirdAddr;
  logic [13:0] oDigitAddr;
  logic [15:0] oColorIndex;
  logic        oValid;

  layer_render_pipeline #(
    .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH), .BG_WIDTH(BGW), .BIRD_X(BX),
    .BIRD_WIDTH(BW), .BIRD_HEIGHT(BH), .BIRD_FRAMES(BF), .FLAP_DIV(FD),
    .SCROLL_DIV(SD), .NUM_DIGITS(ND), .DIGIT_WIDTH(DW), .DIGIT_HEIGHT(DH),
    .SCORE_X(SX), .SCORE_Y(SY), .SCORE_MARGIN(SM), .LEADING_ZEROS(LZ)
  ) dut (
    .iClock(iClock), .iReset(iReset), .iValid(iValid), .iAddress(iAddress),
    .iBirdY(iBirdY), .iScore(iScore), .oBgAddr(oBgAddr), .iBgIdx(iBgIdx),
    .oBirdAddr(oBirdAddr), .iBirdIdx(iBirdIdx), .oDigitAddr(oDigitAddr),
    .iDigitIdx(iDigitIdx), .oColorIndex(oColorIndex), .oValid(oValid)
  );

  always #5 iClock = ~iClock;

  function automatic logic [15:0] bg_rom(input int a);
    return 16'(32'h4000 + a);
  endfunction
  function automatic logic [15:0] bird_rom(input int a);
    return (a % 5 == 2) ? 16'd0 : 16'(32'h8000 + a);
  endfunction
  function automatic logic [15:0] digit_rom(input int a);
    return (a % 7 == 3) ? 16'd0 : 16'(32'hC000 + a);
  endfunction

  // ROMs with one-cycle read latency
  always @(posedge iClock) begin
    iBgIdx    <= bg_rom(int'(oBgAddr));
    iBirdIdx  <= bird_rom(int'(oBirdAddr));
    iDigitIdx <= digit_rom(int'(oDigitAddr));
  end

  int cyc = 0;
  always @(posedge iClock) cyc = cyc + 1;

  typedef struct {
    logic [15:0] col;
    bit          care;
    int          x, y, frame, cyc;
  } exp_t;
  exp_t sb[$];

  int total = 0, bad = 0;
  int frame_no = 0, lat_y = 0, lat_score = 0, pix = 0, gap_pct = 0;
  bit care = 1'b0, bg_pend = 1'b0;
  int bg_exp = 0;

  // Expected colour of pixel (x,y) in the current frame, straight from the layering rules.
  function automatic logic [15:0] model_pixel(input int x, input int y);
    int scroll, anim, sc, gx;
    int dig[ND];
    bit seen;
    logic [15:0] col, v;
    scroll = ((frame_no - 1) / SD) % BGW;
    anim   = ((frame_no - 1) / FD) % BF;
    col    = bg_rom(((x + scroll) % BGW) + y * BGW);
    sc     = (lat_score > MAXS) ? MAXS : lat_score;
    for (int g = 0; g < ND; g++) dig[g] = (sc / (10 ** (ND - 1 - g))) % 10;
    seen = (LZ != 0);
    for (int g = 0; g < ND; g++) begin
      seen = seen || (dig[g] != 0) || (g == ND - 1);
      gx = SX + g * (DW + SM);
      if (seen && x >= gx && x < gx + DW && y >= SY && y < SY + DH) begin
        v = digit_rom(dig[g] * DW * DH + (y - SY) * DW + (x - gx));
        if (v != 0) col = v;
      end
    end
    if (x >= BX && x < BX + BW && y >= lat_y && y < lat_y + BH) begin
      v = bird_rom(anim * BW * BH + (y - lat_y) * BW + (x - BX));
      if (v != 0) col = v;
    end
    return col;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge iClock);
      #1;
      if (oValid) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_valid: oValid=1 with no pixel outstanding at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          if (cyc - e.cyc != 3) begin
            bad++;
            $display("FAIL latency: got %0d cycles, want 3 (frame %0d px %0d,%0d)", cyc - e.cyc, e.frame, e.x, e.y);
          end
          if (e.care) begin
            total++;
            if (oColorIndex !== e.col) begin
              bad++;
              $display("FAIL pixel frame %0d (%0d,%0d): oColorIndex=%h want %h", e.frame, e.x, e.y, oColorIndex, e.col);
            end
          end
        end
      end
    end
  end

  task automatic check_bg_pend();
    if (bg_pend) begin
      bg_pend = 1'b0;
      total++;
      if (oBgAddr !== 17'(bg_exp)) begin
        bad++;
        $display("FAIL frame_start_bgaddr frame %0d: oBgAddr=%0d want %0d", frame_no, oBgAddr, bg_exp);
      end
    end
  endtask

  task automatic pixel(input bit start, input int by, input int sc);
    exp_t e;
    @(negedge iClock);
    check_bg_pend();
    for (int i = 0; i < 3 && $urandom_range(0, 99) < gap_pct; i++) begin
      iValid = 1'b0;
      @(negedge iClock);
    end
    iValid = 1'b1;
    if (start) begin
      iAddress  = '0;
      iBirdY    = 10'(by);
      iScore    = 16'(sc);
      frame_no++;
      lat_y     = by;
      lat_score = sc;
      pix       = 0;
      care      = 1'b1;
      bg_pend   = 1'b1;
      bg_exp    = ((frame_no - 1) / SD) % BGW;
    end else begin
      iAddress = 19'(pix);
      iBirdY   = 10'($urandom);
      iScore   = 16'($urandom);
    end
    e.care  = care;
    e.x     = pix % SW;
    e.y     = pix / SW;
    e.frame = frame_no;
    e.cyc   = cyc;
    e.col   = care ? model_pixel(e.x, e.y) : 16'd0;
    sb.push_back(e);
    pix++;
  endtask

  task automatic run_frame(input int npix, input int by, input int sc);
    pixel(1'b1, by, sc);
    for (int p = 1; p < npix; p++) pixel(1'b0, 0, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge iClock);
      check_bg_pend();
      iValid = 1'b0;
    end
  endtask

  initial begin : stim
    repeat (3) @(negedge iClock);
    total += 2;
    if (oValid !== 1'b0) begin bad++; $display("FAIL reset_valid: oValid=%b want 0", oValid); end
    if (oColorIndex !== 16'd0) begin bad++; $display("FAIL reset_color: oColorIndex=%h want 0", oColorIndex); end
    iReset = 1'b0;
    idle(2);

    gap_pct = 0;
    run_frame(FULL, 3, 1234);
    gap_pct = 20;
    run_frame(FULL, SH - 2, 7);
    gap_pct = 0;
    run_frame(5, 10, 42);
    run_frame(FULL, 10, 285);

    gap_pct = 10;
    for (int f = 0; f < 22; f++)
      run_frame(60, $urandom_range(0, SH), $urandom_range(0, 1200));

    run_frame(300, 4, 55);
    @(negedge iClock);
    iValid = 1'b0;
    iReset = 1'b1;
    #1;
    total += 2;
    if (oValid !== 1'b0) begin bad++; $display("FAIL midreset_valid: oValid=%b want 0", oValid); end
    if (oColorIndex !== 16'd0) begin bad++; $display("FAIL midreset_color: oColorIndex=%h want 0", oColorIndex); end
    sb.delete();
    frame_no = 0;
    care     = 1'b0;
    bg_pend  = 1'b0;
    repeat (2) @(negedge iClock);
    iReset = 1'b0;
    for (int p = 0; p < 20; p++) pixel(1'b0, 0, 0);

    gap_pct = 15;
    run_frame(FULL, $urandom_range(0, SH), $urandom_range(0, 1200));
    run_frame(FULL, $urandom_range(0, SH), $urandom_range(0, 99));
    run_frame(FULL, $urandom_range(0, SH), $urandom_range(1000, 65535));
    idle(10);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d pixels never produced, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/layer_render_pipeline.md
LAYER_RENDER_PIPELINE -- requirements
Module: layer_render_pipeline

Interface
REQ-001 Parameters (name, default, meaning), one per line:
 SCREEN_WIDTH, 640, pixels per line
 SCREEN_HEIGHT, 480, lines per frame
 BG_WIDTH, 260, background tile width
 BIRD_X, 303, sprite left column
 BIRD_WIDTH, 34, sprite width
 BIRD_HEIGHT, 24, sprite height
 BIRD_FRAMES, 3, animation frames
 FLAP_DIV, 6, frames per animation step
 SCROLL_DIV, 1, frames per 1-pixel background scroll
 NUM_DIGITS, 3, score digits shown
 DIGIT_WIDTH, 24, glyph width
 DIGIT_HEIGHT, 44, glyph height
 SCORE_X, 10, leftmost glyph column
 SCORE_Y, 10, glyph top row
 SCORE_MARGIN, 5, gap between glyphs
 LEADING_ZEROS, 0, 1 = show leading zeros, 0 = blank them
REQ-002 Ports (name, direction, width, meaning), one per line:
 iClock, in, 1, sole clock, rising edge
 iReset, in, 1, asynchronous active-high reset
 iValid, in, 1, iAddress carries a pixel this cycle
 iAddress, in, 19, linear pixel address; 0 marks frame start
 iBirdY, in, 10, sprite top row
 iScore, in, 16, binary score
 oBgAddr, out, 17, background ROM address
 iBgIdx, in, 16, background ROM data, one-cycle read latency
 oBirdAddr, out, 12, sprite ROM address (frame*W*H + offset)
 iBirdIdx, in, 16, sprite ROM data, one-cycle read latency
 oDigitAddr, out, 14, glyph ROM address (digit*DIGIT_WIDTH*DIGIT_HEIGHT + offset)
 iDigitIdx, in, 16, glyph ROM data, one-cycle read latency
 oColorIndex, out, 16, composited colour index
 oValid, out, 1, oColorIndex valid

Function
REQ-003 Internal x/y counters SHALL track position: iValid with iAddress==0 loads x=0,y=0; every other iValid advances x, wrapping SCREEN_WIDTH-1 to 0 and incrementing y; no divider on iAddress.
REQ-004 Frame start (iValid and iAddress==0) SHALL latch iBirdY and iScore into frame registers; mid-frame input changes SHALL have no visible effect.
REQ-005 Stage 1 (cycle after iValid): register region flags and ROM addresses; stage 2: ROM data returns; stage 3: register oColorIndex; oValid SHALL equal iValid delayed exactly 3 cycles; no back-pressure; consecutive pixels fully pipelined.
REQ-006 oBgAddr SHALL be ((x + scroll) mod BG_WIDTH) + y*BG_WIDTH; scroll increments every SCROLL_DIV frame starts, wrapping BG_WIDTH-1 to 0.
REQ-007 Sprite region: BIRD_X <= x < BIRD_X+BIRD_WIDTH and Y <= y < Y+BIRD_HEIGHT using latched Y; compared at 11 bits, so Y+BIRD_HEIGHT beyond SCREEN_HEIGHT clips, never wraps.
REQ-008 Animation frame SHALL advance every FLAP_DIV frame starts, wrapping BIRD_FRAMES-1 to 0.
REQ-009 Glyph k (k=0 leftmost) region starts at SCORE_X + k*(DIGIT_WIDTH+SCORE_MARGIN); outside all regions oBirdAddr and oDigitAddr SHALL be 0.
REQ-010 Score converter FSM states: IDLE, CONVERT, DONE. Frame start -> CONVERT with value min(score, 10^NUM_DIGITS - 1); CONVERT subtracts one power of ten per cycle, most significant digit first; all digits resolved -> DONE (one cycle), then IDLE.
REQ-011 Displayed digits SHALL be double-buffered and update only on DONE; a frame start during CONVERT restarts conversion with the new score, display unchanged.
REQ-012 Conversion SHALL finish within 9*NUM_DIGITS+2 cycles, before row SCORE_Y.
REQ-013 LEADING_ZEROS=0: zero digits left of the first non-zero digit are transparent; the rightmost digit always displays.
REQ-014 Priority, index 0 = transparent: sprite (non-zero) > glyph (non-zero) > background.

Reset
REQ-015 iReset SHALL asynchronously clear counters, scroll, animation frame, pipeline, displayed digits (all 0), latched Y/score and oValid; oColorIndex=0; FSM=IDLE.
REQ-016 Reset mid-frame SHALL suppress oValid until 3 cycles after the next accepted iValid; output is meaningful only after the next frame start.

Verification
REQ-017 Reset, then frame start with iValid continuous -> oValid rises exactly 3 cycles later; first oBgAddr=0.
REQ-018 SCROLL_DIV=1, 260 frame starts -> scroll 0..259 then 0; pixel (0,0) oBgAddr follows scroll.
REQ-019 iBirdY=470, sprite iBirdIdx=5 -> rows 470-479 index 5 at x 303-336; x=302/337 and row 0 show background.
REQ-020 iScore=1234, NUM_DIGITS=3 -> 9,9,9; iScore=7, LEADING_ZEROS=0 -> left two glyphs transparent, rightmost digit 7.
REQ-021 Second frame start 5 cycles after the first, score 42 -> 285 -> conversion restarts, displayed digits become 2,8,5, never 0,4,2.
REQ-022 iBirdY changed mid-frame -> sprite rows unchanged until next frame start.
